multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
// Moore control FSM that sequences the MIPS datapath as a multi-cycle machine: one shared
//   memory, one ALU, an instruction register, and PC update through a pc_source mux.
// Decodes opcode/funct once per instruction and steps FETCH->DECODE->exec states.
// Inserts memory wait states via mem_ready, counts retired instructions, and flags illegal opcodes.
// PARAMETERS
// CNT_W    32  width of retired-instruction counter instret (wraps modulo 2^CNT_W)
// WAIT_EN  1   1: memory states hold until mem_ready=1; 0: mem_ready ignored (treated as 1)
// PORTS
// clk            in   1      rising-edge clock; all state updates on this edge
// rst            in   1      synchronous reset, active-high
// opcode         in   6      instr[31:26] from the instruction register
// funct          in   6      instr[5:0] from the instruction register
// zero           in   1      ALU zero flag
// mem_ready      in   1      memory access completes this cycle
// pc_write       out  1      unconditional PC load
// pc_write_cond  out  1      PC load qualified by zero (BEQ)
// iord           out  1      memory address select: 0=PC, 1=ALUOut
// mem_read       out  1      memory read strobe
// mem_write      out  1      memory write strobe
// ir_write       out  1      instruction register load
// mem_to_reg     out  1      register write data: 0=ALUOut, 1=MDR
// reg_dst        out  1      write address: 0=rt, 1=rd
// reg_write      out  1      register file write enable
// alu_src_a      out  1      ALU A: 0=PC, 1=regA
// alu_src_b      out  2      ALU B: 00=regB, 01=4, 10=signext, 11=signext<<2
// alu_op         out  2      00=add, 01=sub, 10=use funct
// pc_source      out  2      00=ALU result, 01=ALUOut, 10=jump target
// illegal_op     out  1      one-cycle pulse in DECODE on unsupported opcode
// state          out  4      current state encoding (debug)
// instret        out  CNT_W  retired-instruction count
// BEHAVIOUR
// States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7
//   BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11; codes 12-15 unreachable, next state FETCH.
// Reset: state=FETCH, instret=0; all outputs are Moore decodes of state, so they are at
//   FETCH values the cycle after reset. rst mid-instruction aborts it; no count.
// Outputs per state (unlisted outputs = 0):
//   FETCH : mem_read=1, alu_src_b=01, ir_write=pc_write=rdy (rdy = mem_ready|~WAIT_EN)
//   DECODE: alu_src_b=11 (branch target precompute)
//   MEMADR/ADDIEX: alu_src_a=1, alu_src_b=10 | MEMRD: mem_read=1, iord=1
//   MEMWB : reg_write=1, mem_to_reg=1 | MEMWR: mem_write=1, iord=1
//   EXEC  : alu_src_a=1, alu_op=10 | ALUWB: reg_write=1, reg_dst=1 | ADDIWB: reg_write=1
//   BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01
//   JUMP  : pc_write=1, pc_source=10
// Transitions: FETCH->DECODE when rdy, else hold. DECODE by opcode: 000000->EXEC,
//   100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->FETCH
//   with illegal_op=1. MEMADR->MEMRD (lw) / MEMWR (sw). MEMRD->MEMWB when rdy, else hold.
//   MEMWR->FETCH when rdy, else hold. EXEC->ALUWB, ADDIEX->ADDIWB.
//   MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, MEMWR(rdy) -> FETCH.
// Strobes mem_read/mem_write stay asserted through wait states; no double write.
// instret += 1 on every transition into FETCH from a completing state (not after illegal).
// funct only affects the datapath ALU decoder; the FSM does not qualify it.
// CPI with rdy=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
// TESTING
// reset high 2 cycles -> state=0, instret=0, mem_read=1, pc_write=1 (mem_ready=1)
// lw, mem_ready=1 -> states 0,1,2,3,4,0; reg_write+mem_to_reg only in MEMWB; instret=1
// sw, mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, then FETCH; instret+1
// beq zero=1 and zero=0 -> 3 cycles each, pc_write_cond=1, pc_source=01 in BRANCH
// opcode 111111 -> illegal_op pulse in DECODE, back to FETCH, instret unchanged
// rst asserted in MEMRD -> next cycle state=FETCH, instret=0, no reg_write pulse

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM sequencing a multi-cycle MIPS datapath (shared memory, one ALU).
// Decodes the opcode once in DECODE, inserts memory wait states and counts retired instructions.
module multicycle_ctrl_fsm #(
    parameter int unsigned CNT_W   = 32,
    parameter bit          WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur, nxt;
    logic   rdy;
    logic   retire;

    // zero and funct are consumed by the datapath, not by this controller
    logic unused_inputs;
    assign unused_inputs = zero ^ (^funct);

    assign rdy   = mem_ready | ~WAIT_EN;
    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= FETCH;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        nxt           = FETCH;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
                nxt       = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      nxt = EXEC;
                    OP_LW, OP_SW:  nxt = MEMADR;
                    OP_BEQ:        nxt = BRANCH;
                    OP_ADDI:       nxt = ADDIEX;
                    OP_J:          nxt = JUMP;
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                nxt      = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                nxt       = rdy ? FETCH : MEMWR;
                retire    = rdy;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: instruction-level reference model
// (per-opcode step lists with random memory waits) checked cycle by cycle.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instret;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] model_cnt = '0;

    multicycle_ctrl_fsm #(.CNT_W(32), .WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic rdy,
                                             input logic [5:0] op);
        logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, ao, ps;
        {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  begin sb = 2'b11; ill = ~is_legal(op); end
            4'd2, 4'd9: begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; io = 1; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            4'd10: rw = 1;
            4'd11: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
    endfunction

    task automatic get_path(input logic [5:0] op, output int n, output logic [3:0] p [6]);
        p = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        case (op)
            6'b100011: begin p[2] = 4'd2; p[3] = 4'd3; p[4] = 4'd4; n = 5; end
            6'b101011: begin p[2] = 4'd2; p[3] = 4'd5; n = 4; end
            6'b000000: begin p[2] = 4'd6; p[3] = 4'd7; n = 4; end
            6'b001000: begin p[2] = 4'd9; p[3] = 4'd10; n = 4; end
            6'b000100: begin p[2] = 4'd8; n = 3; end
            6'b000010: begin p[2] = 4'd11; n = 3; end
            default:   n = 2;
        endcase
    endtask

    // Entered in the low clock phase; applies inputs, checks, then advances one clock.
    task automatic do_cycle(input logic [3:0] st, input logic mr);
        logic [16:0] got, exp;
        mem_ready = mr;
        zero  = 1'($urandom);
        funct = 6'($urandom);
        #1;
        got = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
        exp = exp_outs(st, mr, opcode);
        n_checks++;
        if (state !== st) begin
            n_fail++;
            $display("FAIL state: got %0d expected %0d (op %b)", state, st, opcode);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL outputs st%0d: got %b expected %b", st, got, exp);
        end
        n_checks++;
        if (instret !== model_cnt) begin
            n_fail++;
            $display("FAIL instret: got %0d expected %0d", instret, model_cnt);
        end
        @(negedge clk);
    endtask

    // waits < 0 selects a random wait count per memory step
    task automatic run_instr(input logic [5:0] op, input int waits, input int max_wait);
        int n, w;
        logic [3:0] p [6];
        opcode = op;
        get_path(op, n, p);
        for (int i = 0; i < n; i++) begin
            if (p[i] inside {4'd0, 4'd3, 4'd5}) begin
                w = (waits >= 0 && p[i] != 4'd0) ? waits :
                    (waits >= 0 ? 0 : int'($urandom_range(max_wait, 0)));
                for (int k = 0; k < w; k++) do_cycle(p[i], 1'b0);
                do_cycle(p[i], 1'b1);
            end else begin
                do_cycle(p[i], 1'($urandom));
            end
        end
        if (is_legal(op)) model_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0 || instret !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got st%0d cnt%0d expected st0 cnt0", state, instret);
        end
        n_checks++;
        if (mem_read !== 1'b1 || pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outs: got mr%b pw%b expected mr1 pw1", mem_read, pc_write);
        end
        rst = 1'b0;
        model_cnt = '0;
    endtask

    task automatic test_lw();        run_instr(6'b100011, 0, 0); endtask
    task automatic test_sw_wait();   run_instr(6'b101011, 3, 0); endtask
    task automatic test_rtype_addi_j();
        run_instr(6'b000000, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b000010, 0, 0);
    endtask
    task automatic test_beq();
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000100, 0, 0);
    endtask
    task automatic test_illegal();   run_instr(6'b111111, 0, 0); endtask

    task automatic test_random();
        logic [5:0] ops [8];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b000010, 6'b111111, 6'b010001};
        for (int i = 0; i < 40; i++) run_instr(ops[$urandom_range(7, 0)], -1, 3);
    endtask

    task automatic test_reset_midinstr();
        opcode = 6'b100011;
        do_cycle(4'd0, 1'b1);
        do_cycle(4'd1, 1'b1);
        do_cycle(4'd2, 1'b1);
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd3) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got st%0d expected st3", state);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0 || instret !== '0 || reg_write !== 1'b0 || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got st%0d cnt%0d rw%b mr%b expected st0 cnt0 rw0 mr1",
                     state, instret, reg_write, mem_read);
        end
        rst = 1'b0;
        model_cnt = '0;
        run_instr(6'b000100, 0, 0);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype_addi_j();
        test_beq();
        test_illegal();
        test_random();
        test_reset_midinstr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
